// File: rtl/cic_decimator.sv
// Third-order CIC (sinc^3) decimator for a 1-bit delta-sigma bitstream.
// Bits are accepted only when bit_valid is high. Every R-th accepted bit
// captures the third integrator; the comb chain runs on the following edge,
// and the result reaches the output holding register one edge after that.
// The first three decimated samples after reset are discarded while the
// comb delay line fills.
module cic_decimator #(
    parameter int LOG2R = 6,
    localparam int W = 3 * LOG2R + 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                bit_i,
    input  logic                bit_valid,
    output logic signed [W-1:0] pcm_data,
    output logic                pcm_valid,
    input  logic                pcm_ready,
    output logic                overrun
);

    typedef enum logic {
        WARMUP,
        RUN
    } state_t;

    localparam logic signed [W-1:0] PLUS_ONE  = W'(1);
    localparam logic signed [W-1:0] MINUS_ONE = '1;

    logic signed [W-1:0] sample_s;
    logic signed [W-1:0] integ1_q, integ2_q, integ3_q;
    logic signed [W-1:0] integ1_d, integ2_d, integ3_d;
    logic [LOG2R-1:0]    dec_cnt_q;
    logic signed [W-1:0] capture_q;
    logic                dec_stb_q;
    logic signed [W-1:0] comb1_d, comb2_d, comb3_d;
    logic signed [W-1:0] dly1_q, dly2_q, dly3_q;
    logic signed [W-1:0] comb_out_q;
    logic                comb_vld_q;
    state_t              state_q;
    logic [1:0]          discard_q;
    logic signed [W-1:0] pcm_data_q;
    logic                pcm_valid_q;
    logic                overrun_q;

    assign sample_s = bit_i ? PLUS_ONE : MINUS_ONE;

    // Integrator chain next values; all sums wrap modulo 2^W.
    always_comb begin
        integ1_d = integ1_q + sample_s;
        integ2_d = integ2_q + integ1_d;
        integ3_d = integ3_q + integ2_d;
    end

    // Integrators advance only on accepted bits and hold during gaps.
    always_ff @(posedge clock) begin
        if (reset) begin
            integ1_q <= '0;
            integ2_q <= '0;
            integ3_q <= '0;
        end else if (bit_valid) begin
            integ1_q <= integ1_d;
            integ2_q <= integ2_d;
            integ3_q <= integ3_d;
        end
    end

    // Decimation counter; the accepted bit that wraps it captures integrator 3.
    always_ff @(posedge clock) begin
        if (reset) begin
            dec_cnt_q <= '0;
            capture_q <= '0;
            dec_stb_q <= 1'b0;
        end else begin
            dec_stb_q <= 1'b0;
            if (bit_valid) begin
                dec_cnt_q <= dec_cnt_q + 1'b1;
                if (dec_cnt_q == '1) begin
                    capture_q <= integ3_d;
                    dec_stb_q <= 1'b1;
                end
            end
        end
    end

    // Comb chain at the decimated rate, differential delay of one sample.
    always_comb begin
        comb1_d = capture_q - dly1_q;
        comb2_d = comb1_d - dly2_q;
        comb3_d = comb2_d - dly3_q;
    end

    // Comb delay registers and the registered comb result.
    always_ff @(posedge clock) begin
        if (reset) begin
            dly1_q     <= '0;
            dly2_q     <= '0;
            dly3_q     <= '0;
            comb_out_q <= '0;
            comb_vld_q <= 1'b0;
        end else begin
            comb_vld_q <= dec_stb_q;
            if (dec_stb_q) begin
                dly1_q     <= capture_q;
                dly2_q     <= comb1_d;
                dly3_q     <= comb2_d;
                comb_out_q <= comb3_d;
            end
        end
    end

    // Warm-up/run control with the output holding register and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= WARMUP;
            discard_q   <= 2'd0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (pcm_valid_q && pcm_ready) begin
                pcm_valid_q <= 1'b0;
            end
            if (comb_vld_q) begin
                case (state_q)
                    WARMUP: begin
                        discard_q <= discard_q + 2'd1;
                        if (discard_q == 2'd2) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        pcm_data_q  <= comb_out_q;
                        pcm_valid_q <= 1'b1;
                        if (pcm_valid_q && !pcm_ready) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= WARMUP;
                endcase
            end
        end
    end

    assign pcm_data  = pcm_data_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: directed and random bitstreams checked against a
// sinc^3 convolution model computed from the list of accepted bits.
module tb_cic_decimator;

    localparam int LOG2R = 6;
    localparam int R     = 1 << LOG2R;
    localparam int W     = 3 * LOG2R + 2;
    localparam int NTAP  = 3 * R - 2;

    logic                clock;
    logic                reset;
    logic                bit_i;
    logic                bit_valid;
    logic signed [W-1:0] pcm_data;
    logic                pcm_valid;
    logic                pcm_ready;
    logic                overrun;

    cic_decimator #(.LOG2R(LOG2R)) dut (
        .clock     (clock),
        .reset     (reset),
        .bit_i     (bit_i),
        .bit_valid (bit_valid),
        .pcm_data  (pcm_data),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .overrun   (overrun)
    );

    int    checks = 0;
    int    errors = 0;
    int    h[NTAP];
    int    acc[$];
    int    expq[$];
    int    rises[$];
    int    nsamp;
    int    cyc;
    logic  prev_valid;
    bit    chk_en;
    string tag;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    // Decimated output ending at the newest accepted bit: sum of h[k]*x[n-k].
    function automatic int model_val();
        int n = acc.size() - 1;
        int s = 0;
        for (int k = 0; k < NTAP; k++) begin
            if (n - k >= 0) s += h[k] * acc[n - k];
        end
        return s;
    endfunction

    task automatic check(input string name, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", name, obs, expv);
        end
    endtask

    task automatic clear_model();
        acc.delete();
        expq.delete();
        rises.delete();
        nsamp      = 0;
        cyc        = 0;
        prev_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        bit_valid = 1'b0;
        bit_i     = 1'b0;
        pcm_ready = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    // One clock: drive inputs, score a transfer happening at this edge, step.
    task automatic cycle(input logic b, input logic bv, input logic rdy);
        logic signed [31:0] obs;
        int                 ev;
        bit_i     = b;
        bit_valid = bv;
        pcm_ready = rdy;
        if (chk_en && pcm_valid && rdy) begin
            obs = pcm_data;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $error("FAIL %s_extra observed %0d expected no sample", tag, obs);
            end else begin
                ev = expq.pop_front();
                assert (obs === ev) else begin
                    errors++;
                    $error("FAIL %s observed %0d expected %0d", tag, obs, ev);
                end
            end
        end
        if (bv) begin
            acc.push_back(b ? 1 : -1);
            if (acc.size() % R == 0) begin
                nsamp++;
                if (nsamp > 3) expq.push_back(model_val());
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        if (pcm_valid && !prev_valid) rises.push_back(cyc);
        prev_valid = pcm_valid;
    endtask

    task automatic drain(input string name);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        check(name, expq.size(), 0);
    endtask

    task automatic wait_first(input logic b);
        for (int i = 0; i < 400; i++) begin
            cycle(b, 1'b1, 1'b1);
            if (pcm_valid) break;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bit_i     = 1'b0;
        bit_valid = 1'b0;
        pcm_ready = 1'b1;
        chk_en    = 1'b1;
        tag       = "init";
        for (int k = 0; k < NTAP; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c]++;

        // Outputs while reset is held
        repeat (2) @(posedge clock);
        #1;
        check("rst_data", pcm_data, 0);
        check("rst_valid", pcm_valid, 0);
        check("rst_overrun", overrun, 0);

        // All ones: latency and full-scale positive output
        do_reset(1);
        tag = "ones";
        wait_first(1'b1);
        check("ones_latency", cyc, 4 * R + 2);
        check("ones_first", pcm_data, 262144);
        repeat (300) cycle(1'b1, 1'b1, 1'b1);
        check("ones_overrun", overrun, 0);
        drain("ones_drain");

        // All zeros: full-scale negative output
        do_reset(1);
        tag = "zeros";
        wait_first(1'b0);
        check("zeros_first", pcm_data, -262144);
        repeat (300) cycle(1'b0, 1'b1, 1'b1);
        drain("zeros_drain");

        // Alternating 1,0: output must be exactly zero
        do_reset(1);
        tag = "alt";
        for (int i = 0; i < 600; i++) begin
            cycle(1'(i % 2 == 0), 1'b1, 1'b1);
            if (pcm_valid) check("alt_zero", pcm_data, 0);
        end
        drain("alt_drain");

        // 1,1,0 repeating: mean 1/3 of full scale within R^2
        do_reset(1);
        tag = "third";
        for (int i = 0; i < 700; i++) begin
            cycle(1'(i % 3 != 2), 1'b1, 1'b1);
            if (pcm_valid) begin
                int d;
                d = int'(pcm_data) - 87381;
                if (d < 0) d = -d;
                check("third_near_mean", 32'(d <= R * R), 1);
            end
        end
        drain("third_drain");

        // Random bits with random bit_valid gaps
        do_reset(1);
        tag = "random";
        for (int i = 0; i < 4000; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        check("random_overrun", overrun, 0);
        drain("random_drain");

        // bit_valid 1-of-3 with ones: same values, 3x spacing
        do_reset(1);
        tag = "gap3";
        for (int i = 0; i < 1400; i++)
            cycle(1'b1, 1'(i % 3 == 0), 1'b1);
        check("gap3_first", rises[0], 3 * 4 * R);
        check("gap3_space1", rises[1] - rises[0], 3 * R);
        check("gap3_space2", rises[2] - rises[1], 3 * R);
        drain("gap3_drain");

        // Back-pressure for two decimation periods causes overrun
        do_reset(1);
        tag = "ovr";
        wait_first(1'b1);
        chk_en = 1'b0;
        repeat (2 * R + 2) cycle(1'b1, 1'b1, 1'b0);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", pcm_valid, 1);
        check("ovr_data", pcm_data, 262144);
        cycle(1'b1, 1'b1, 1'b1);
        check("ovr_xfer_clears", pcm_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Reset pulse mid-run with a pending sample
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (pcm_valid) break;
        end
        check("pend_valid", pcm_valid, 1);
        reset     = 1'b1;
        bit_valid = 1'b0;
        pcm_ready = 1'b1;
        @(posedge clock);
        #1;
        check("pulse_valid", pcm_valid, 0);
        check("pulse_overrun", overrun, 0);
        reset = 1'b0;
        clear_model();
        chk_en = 1'b1;
        tag = "restart";
        wait_first(1'b1);
        check("restart_latency", cyc, 4 * R + 2);
        check("restart_data", pcm_data, 262144);
        repeat (150) cycle(1'b1, 1'b1, 1'b1);
        drain("restart_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
